dual_ram_stream_reader: RTL

//   Read-side master for dual_ram: sweeps a block of words from the RAM read port and streams them out on a

---
 rtl/dual_ram_stream_reader_if.sv | 23 ++
 rtl/dual_ram_stream_reader.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/dual_ram_stream_reader_if.sv
// Read-side bus of dual_ram_stream_reader: the dual_ram read port plus the
// valid/ready output stream. The master modport is the reader's view.
interface dual_ram_stream_reader_if #(
    parameter int RAM_WIDTH = 8,
    parameter int ADDR_SIZE = 8
);
    logic                 rd_enb;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic [RAM_WIDTH-1:0] ram_data;
    logic                 m_valid;
    logic [RAM_WIDTH-1:0] m_data;
    logic                 m_ready;

    modport master (
        output rd_enb, rd_addr, m_valid, m_data,
        input  ram_data, m_ready
    );

    modport slave (
        input  rd_enb, rd_addr, m_valid, m_data,
        output ram_data, m_ready
    );
endinterface

// File: rtl/dual_ram_stream_reader.sv
// dual_ram_stream_reader: sweeps length words from the dual_ram read port,
// starting at base_addr and wrapping at RAM_DEPTH, and streams them out on
// a valid/ready interface through a 2-entry buffer.
// Optional feature: define READER_CHECKSUM_EN to add a checksum output
// (sum of handshaken words, modulo 2^RAM_WIDTH).
module dual_ram_stream_reader #(
    parameter int RAM_WIDTH = 8,
    parameter int RAM_DEPTH = 256,
    parameter int ADDR_SIZE = 8,
    parameter int LEN_SIZE  = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADDR_SIZE-1:0] base_addr,
    input  logic [LEN_SIZE-1:0]  length,
    output logic                 busy,
    output logic                 done,
`ifdef READER_CHECKSUM_EN
    output logic [RAM_WIDTH-1:0] checksum,
`endif
    dual_ram_stream_reader_if.master bus
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t               state, state_next;
    logic [LEN_SIZE-1:0]  remaining;
    logic [ADDR_SIZE-1:0] rd_addr_q;
    logic                 inflight;
    logic [1:0]           buf_count;
    logic [RAM_WIDTH-1:0] buf0, buf1;
    logic                 pop, push, issue, load, accept, done_next;

    assign pop          = bus.m_valid && bus.m_ready;
    assign push         = inflight;
    assign bus.m_valid  = (buf_count != 2'd0);
    assign bus.m_data   = buf0;
    assign bus.rd_addr  = rd_addr_q;
    // rd_enb sees the current handshake so a word can be issued in the same
    // cycle one leaves; that is what sustains one word per cycle with only
    // two buffer entries while keeping buffered + in-flight words <= 2.
    assign bus.rd_enb   = issue;

    // Next-state, read-issue and completion decisions.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        load       = 1'b0;
        accept     = 1'b0;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    if (length != '0) begin
                        load       = 1'b1;
                        state_next = READ;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            READ: begin
                issue = (({1'b0, buf_count} + {2'b00, inflight}) < 3'd2) || pop;
                if (issue && remaining == LEN_SIZE'(1)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!inflight && (buf_count == 2'd0 || (buf_count == 2'd1 && pop))) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register with registered busy/done flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
            done  <= done_next;
        end
    end

    // Read address and remaining-read counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr_q <= '0;
            remaining <= '0;
        end else if (load) begin
            rd_addr_q <= base_addr;
            remaining <= length;
        end else if (issue) begin
            rd_addr_q <= (rd_addr_q == ADDR_SIZE'(RAM_DEPTH - 1)) ? '0 : rd_addr_q + 1'b1;
            remaining <= remaining - 1'b1;
        end
    end

    // Tracks a read whose data appears on ram_data this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
        end
    end

    // Two-entry output buffer; buf0 is the presented head word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf0      <= '0;
            buf1      <= '0;
            buf_count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b11: begin
                    if (buf_count == 2'd2) begin
                        buf0 <= buf1;
                        buf1 <= bus.ram_data;
                    end else begin
                        buf0 <= bus.ram_data;
                    end
                end
                2'b01: begin
                    buf0      <= buf1;
                    buf_count <= buf_count - 2'd1;
                end
                2'b10: begin
                    if (buf_count == 2'd0) begin
                        buf0 <= bus.ram_data;
                    end else begin
                        buf1 <= bus.ram_data;
                    end
                    buf_count <= buf_count + 2'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef READER_CHECKSUM_EN
    // Running sum of handshaken words, cleared on every accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= '0;
        end else if (pop) begin
            checksum <= checksum + bus.m_data;
        end
    end
`endif

endmodule
